// File: rtl/gmii_chk_pkg.sv
// Shared constants and types for the GMII receive frame checker.
//   PREAMBLE / SFD   : octets expected ahead of the destination address
//   CRC_*            : reflected CRC-32 constants (init value, polynomial, good residue)
//   state_t          : receive FSM states
//   class_t          : one-hot-free frame classification, highest priority last
package gmii_chk_pkg;

  localparam logic [7:0]  PREAMBLE    = 8'h55;
  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } state_t;

  typedef enum logic [2:0] {
    CLS_GOOD,
    CLS_BAD_CRC,
    CLS_RUNT,
    CLS_OVERSIZE,
    CLS_ERR
  } class_t;

endpackage

// File: rtl/crc32_d8.sv
// One-octet step of the reflected CRC-32 (LSB of d processed first).
//   crc_in  : current CRC register
//   d       : octet to absorb
//   crc_out : CRC register after absorbing d
module crc32_d8
  import gmii_chk_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  always_comb begin : step
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_frame_checker.sv
// Receive-side GMII frame checker: strips preamble/SFD, checks the FCS, classifies
// each frame and keeps saturating statistics plus the SFD timestamp of good frames.
//   clk, rst                  : clock, synchronous active-high reset
//   gmii_d/en/er              : GMII receive octet, valid, error
//   sec, nsec                 : shared time base, sampled on the SFD octet
//   clear                     : pulse, zeroes all statistics (FSM untouched)
//   frame_done, frame_ok      : pulse one cycle after classification, and its good qualifier
//   frames_*, octets_good     : saturating statistics counters
//   ifg_min                   : smallest idle gap seen between frames, in cycles
//   last_sec, last_nsec       : SFD timestamp of the most recent good frame
module gmii_frame_checker
  import gmii_chk_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int LEN_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           gmii_d,
  input  logic                 gmii_en,
  input  logic                 gmii_er,
  input  logic [47:0]          sec,
  input  logic [29:0]          nsec,
  input  logic                 clear,
  output logic                 frame_done,
  output logic                 frame_ok,
  output logic [CNT_WIDTH-1:0] frames_total,
  output logic [CNT_WIDTH-1:0] frames_good,
  output logic [CNT_WIDTH-1:0] frames_bad_crc,
  output logic [CNT_WIDTH-1:0] frames_runt,
  output logic [CNT_WIDTH-1:0] frames_oversize,
  output logic [CNT_WIDTH-1:0] frames_err,
  output logic [CNT_WIDTH-1:0] octets_good,
  output logic [31:0]          ifg_min,
  output logic [47:0]          last_sec,
  output logic [29:0]          last_nsec
);

  state_t               state, state_next;
  logic [2:0]           pcnt;
  logic                 err_flag;
  logic [31:0]          crc, crc_next;
  logic [LEN_WIDTH-1:0] len;
  logic [31:0]          gap;
  logic [47:0]          ts_sec;
  logic [29:0]          ts_nsec;
  logic                 frame_seen;
  logic                 start_pre, pre_inc, set_err, start_data, take_data;
  logic                 classify, force_err;
  class_t               cls;
  logic [CNT_WIDTH:0]   oct_sum;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  crc32_d8 u_crc (
    .crc_in  (crc),
    .d       (gmii_d),
    .crc_out (crc_next)
  );

  // Starting in DROP means a frame already on the wire at reset release is
  // swallowed without being counted (err_flag is clear).
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= DROP;
    else     state <= state_next;
  end

  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    start_pre  = 1'b0;
    pre_inc    = 1'b0;
    set_err    = 1'b0;
    start_data = 1'b0;
    take_data  = 1'b0;
    classify   = 1'b0;
    force_err  = 1'b0;
    unique case (state)
      IDLE: if (gmii_en) begin
        if (gmii_d == PREAMBLE) begin
          state_next = PRE;
          start_pre  = 1'b1;
        end else begin
          state_next = DROP;
          set_err    = 1'b1;
        end
      end
      PRE: begin
        if (!gmii_en) begin
          // Carrier lost inside the preamble: truncated frame.
          state_next = IDLE;
          classify   = 1'b1;
          force_err  = 1'b1;
        end else if (gmii_d == PREAMBLE) begin
          // pcnt already holds the preamble octets seen; an eighth one is illegal.
          if (pcnt >= 3'd7) begin
            state_next = DROP;
            set_err    = 1'b1;
          end else begin
            pre_inc = 1'b1;
          end
        end else if (gmii_d == SFD) begin
          state_next = DATA;
          start_data = 1'b1;
        end else begin
          state_next = DROP;
          set_err    = 1'b1;
        end
      end
      DATA: begin
        if (gmii_en) begin
          take_data = 1'b1;
        end else begin
          state_next = IDLE;
          classify   = 1'b1;
        end
      end
      DROP: if (!gmii_en) begin
        state_next = IDLE;
        classify   = err_flag;
        force_err  = 1'b1;
      end
    endcase
  end

  // Priority: err > runt > oversize > bad_crc > good.
  always_comb begin
    cls = CLS_GOOD;
    if (force_err || err_flag)                  cls = CLS_ERR;
    else if (len < LEN_WIDTH'(MIN_FRAME))       cls = CLS_RUNT;
    else if (len > LEN_WIDTH'(MAX_FRAME))       cls = CLS_OVERSIZE;
    else if (crc != CRC_RESIDUE)                cls = CLS_BAD_CRC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt     <= '0;
      err_flag <= 1'b0;
      crc      <= CRC_INIT;
      len      <= '0;
      gap      <= '0;
      ts_sec   <= '0;
      ts_nsec  <= '0;
    end else begin
      if (start_pre) begin
        pcnt     <= 3'd1;
        err_flag <= 1'b0;
      end else if (pre_inc) begin
        pcnt <= pcnt + 3'd1;
      end
      if (set_err || (take_data && gmii_er)) err_flag <= 1'b1;

      if (start_data) begin
        crc     <= CRC_INIT;
        len     <= '0;
        ts_sec  <= sec;
        ts_nsec <= nsec;
      end else if (take_data) begin
        crc <= crc_next;
        if (~&len) len <= len + LEN_WIDTH'(1);
      end

      // Gap restarts when the FSM enters IDLE and counts each idle cycle after.
      if (state_next == IDLE && state != IDLE)  gap <= '0;
      else if (state == IDLE && !gmii_en && ~&gap) gap <= gap + 32'd1;
    end
  end

  assign oct_sum = {1'b0, octets_good} + (CNT_WIDTH + 1)'(len);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done      <= 1'b0;
      frame_ok        <= 1'b0;
      frames_total    <= '0;
      frames_good     <= '0;
      frames_bad_crc  <= '0;
      frames_runt     <= '0;
      frames_oversize <= '0;
      frames_err      <= '0;
      octets_good     <= '0;
      ifg_min         <= '1;
      frame_seen      <= 1'b0;
      last_sec        <= '0;
      last_nsec       <= '0;
    end else begin
      frame_done <= classify;
      frame_ok   <= classify && (cls == CLS_GOOD);

      if (classify && cls == CLS_GOOD) begin
        last_sec  <= ts_sec;
        last_nsec <= ts_nsec;
      end

      // clear beats a coincident classification; ifg_min returns to its
      // "nothing measured" value so later gaps can still lower it.
      if (clear) begin
        frames_total    <= '0;
        frames_good     <= '0;
        frames_bad_crc  <= '0;
        frames_runt     <= '0;
        frames_oversize <= '0;
        frames_err      <= '0;
        octets_good     <= '0;
        ifg_min         <= '1;
        frame_seen      <= 1'b0;
      end else begin
        if (classify) begin
          frames_total <= sat_inc(frames_total);
          frame_seen   <= 1'b1;
          unique case (cls)
            CLS_GOOD: begin
              frames_good <= sat_inc(frames_good);
              octets_good <= oct_sum[CNT_WIDTH] ? '1 : oct_sum[CNT_WIDTH-1:0];
            end
            CLS_BAD_CRC:  frames_bad_crc  <= sat_inc(frames_bad_crc);
            CLS_RUNT:     frames_runt     <= sat_inc(frames_runt);
            CLS_OVERSIZE: frames_oversize <= sat_inc(frames_oversize);
            CLS_ERR:      frames_err      <= sat_inc(frames_err);
          endcase
        end
        if (state == IDLE && gmii_en && frame_seen && gap < ifg_min) ifg_min <= gap;
      end
    end
  end

endmodule
